// File: rtl/cla_multiword_seq.sv
// Wide add/subtract sequencer: streams NUM_WORDS words, least-significant first,
// through one DATA_WIDTH-bit carry-lookahead adder, with the carry held in a register.

module CLA_top #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
);
  localparam int unsigned NG = DATA_WIDTH / 4;

  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups; group generate/propagate chain the carry between groups
  always_comb begin
    logic       c;
    logic [3:0] gc;
    logic       gg;
    logic       pg;
    c   = cin;
    sum = '0;
    gc  = '0;
    gg  = 1'b0;
    pg  = 1'b0;
    for (int unsigned k = 0; k < NG; k++) begin
      gc[0] = c;
      gc[1] = g[4*k] | (p[4*k] & c);
      gc[2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c);
      gc[3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
            | (p[4*k+2] & p[4*k+1] & p[4*k] & c);
      gg    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg    = &p[4*k +: 4];
      sum[4*k +: 4] = p[4*k +: 4] ^ gc;
      c = gg | (pg & c);
    end
    cout = c;
  end
endmodule

module cla_multiword_seq #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] op_a,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] op_b,
  input  logic                            sub,
  input  logic                            cin,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] result,
  output logic                            cout,
  output logic                            overflow
);
  localparam int W  = DATA_WIDTH * NUM_WORDS;
  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic            carry_q;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_next;
  logic [W-1:0]    result_q;
  logic            cout_q;
  logic            ovf_q;
  logic [DATA_WIDTH-1:0] cla_sum;
  logic            cla_cout;
  logic            last_word;

  CLA_top #(.DATA_WIDTH(DATA_WIDTH)) u_cla (
    .a    (a_sh[DATA_WIDTH-1:0]),
    .b    (b_sh[DATA_WIDTH-1:0]),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  assign last_word = (cnt == CW'(NUM_WORDS - 1));
  // New sum word enters at the top; after NUM_WORDS shifts word 0 sits at the bottom
  assign acc_next  = W'({cla_sum, acc} >> DATA_WIDTH);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_word) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      carry_q  <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh    <= op_a;
          b_sh    <= sub ? ~op_b : op_b;
          carry_q <= sub ? 1'b1 : cin;
          cnt     <= '0;
        end
        RUN: begin
          a_sh    <= a_sh >> DATA_WIDTH;
          b_sh    <= b_sh >> DATA_WIDTH;
          acc     <= acc_next;
          carry_q <= cla_cout;
          cnt     <= cnt + 1'b1;
          if (last_word) begin
            result_q <= acc_next;
            cout_q   <= cla_cout;
            ovf_q    <= (a_sh[DATA_WIDTH-1] == b_sh[DATA_WIDTH-1]) &&
                        (cla_sum[DATA_WIDTH-1] != a_sh[DATA_WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_cla_multiword_seq.sv
// Directed bench for cla_multiword_seq: 4x64-bit instance plus a 1x16-bit instance.

module tb_cla_multiword_seq;
  localparam int W  = 256;
  localparam int SW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] op_a, op_b, result;
  logic         sub, cin, cout, overflow;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [SW-1:0] s_op_a, s_op_b, s_result;
  logic          s_sub, s_cin, s_cout, s_overflow;

  int n_pass  = 0;
  int n_total = 0;

  cla_multiword_seq #(.DATA_WIDTH(64), .NUM_WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow)
  );

  cla_multiword_seq #(.DATA_WIDTH(16), .NUM_WORDS(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .op_a(s_op_a), .op_b(s_op_b), .sub(s_sub), .cin(s_cin),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .cout(s_cout), .overflow(s_overflow)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Precondition and postcondition: DUT in IDLE, 1 time unit after an edge.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input logic [W-1:0] er,
                        input logic eco, input logic eov, input int stall);
    int lat;
    op_a = a; op_b = b; sub = s; cin = c; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, ".in_ready"}, 256'(in_ready), 256'd1);
    tick();
    in_valid = 1'b0;
    op_a = ~a; op_b = ~b; sub = ~s; cin = ~c;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 256'(lat), 256'd4);
    repeat (stall) tick();
    chk({tag, ".result"}, result, er);
    chk({tag, ".cout"}, 256'(cout), 256'(eco));
    chk({tag, ".overflow"}, 256'(overflow), 256'(eov));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 256'(out_valid), 256'd0);
  endtask

  task automatic run16(input string tag, input logic [SW-1:0] a, input logic [SW-1:0] b,
                       input logic s, input logic c, input logic [SW-1:0] er,
                       input logic eco, input logic eov);
    int lat;
    s_op_a = a; s_op_b = b; s_sub = s; s_cin = c; s_in_valid = 1'b1; s_out_ready = 1'b0;
    tick();
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 256'(lat), 256'd1);
    chk({tag, ".result"}, 256'(s_result), 256'(er));
    chk({tag, ".cout"}, 256'(s_cout), 256'(eco));
    chk({tag, ".overflow"}, 256'(s_overflow), 256'(eov));
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
  endtask

  // Reference: {overflow, cout, result} of the full-width operation
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic c);
    logic [W-1:0] be;
    logic [W:0]   t;
    logic         ov;
    be = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + (W+1)'(s ? 1'b1 : c);
    ov = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return {ov, t};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   max_v, msb_v, ra, rb;
    logic [W+1:0]   m;
    logic           rs, rc;
    logic           seen;
    max_v = '1;
    msb_v = 256'd1 << 255;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_op_a = '0; s_op_b = '0; s_sub = 1'b0; s_cin = 1'b0;
    tick();
    tick();
    chk("reset.in_ready", 256'(in_ready), 256'd1);
    chk("reset.out_valid", 256'(out_valid), 256'd0);
    chk("reset.result", result, '0);
    chk("reset.cout", 256'(cout), 256'd0);
    chk("reset.overflow", 256'(overflow), 256'd0);
    chk("reset.s_out_valid", 256'(s_out_valid), 256'd0);
    rst = 1'b0;
    tick();

    run_op("ripple", max_v, 256'd1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 0);
    run_op("sub_0m1", '0, 256'd1, 1'b1, 1'b0, max_v, 1'b0, 1'b0, 0);
    run_op("sub_minm1", msb_v, 256'd1, 1'b1, 1'b0, msb_v - 256'd1, 1'b1, 1'b1, 0);

    // Reset while RUN with cnt==2
    op_a = 256'd9; op_b = 256'd9; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst.in_ready", 256'(in_ready), 256'd1);
    chk("midrst.out_valid", 256'(out_valid), 256'd0);
    tick();
    rst = 1'b0;
    chk("midrst.result", result, '0);
    chk("midrst.cout", 256'(cout), 256'd0);
    chk("midrst.overflow", 256'(overflow), 256'd0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | out_valid;
    end
    chk("midrst.no_valid", 256'(seen), 256'd0);

    run_op("add_5_7_c1", 256'd5, 256'd7, 1'b0, 1'b1, 256'd13, 1'b0, 1'b0, 0);
    run_op("pos_ovf", msb_v - 256'd1, 256'd1, 1'b0, 1'b0, msb_v, 1'b0, 1'b1, 2);
    run_op("sub_equal", max_v - 256'd5, max_v - 256'd5, 1'b1, 1'b0, '0, 1'b1, 1'b0, 0);
    run_op("cin_only", '0, '0, 1'b0, 1'b1, 256'd1, 1'b0, 1'b0, 0);
    run_op("sub_ign_cin", 256'd10, 256'd3, 1'b1, 1'b1, 256'd7, 1'b1, 1'b0, 0);
    run_op("word_carry", 256'hFFFF_FFFF_FFFF_FFFF, 256'd1, 1'b0, 1'b0,
           256'h1_0000_0000_0000_0000, 1'b0, 1'b0, 1);

    // Backpressure: held DONE ignores new requests
    op_a = 256'd3; op_b = 256'd4; sub = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("bp.valid", 256'(out_valid), 256'd1);
    op_a = 256'd100; op_b = 256'd1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      tick();
      chk("bp.hold_result", result, 256'd7);
      chk("bp.hold_valid", 256'(out_valid), 256'd1);
      chk("bp.hold_in_ready", 256'(in_ready), 256'd0);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.idle_valid", 256'(out_valid), 256'd0);
    chk("bp.idle_in_ready", 256'(in_ready), 256'd1);
    chk("bp.idle_result", result, 256'd7);
    tick();
    in_valid = 1'b0;
    chk("bp.accepted", 256'(in_ready), 256'd0);
    repeat (4) tick();
    chk("bp.new_valid", 256'(out_valid), 256'd1);
    chk("bp.new_result", result, 256'd101);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    run16("s_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run16("s_pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run16("s_neg_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run16("s_borrow", 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      for (int j = 0; j < 8; j++) begin
        ra[32*j +: 32] = $urandom;
        rb[32*j +: 32] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) rb = ~ra;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rs, rc);
      run_op("rand", ra, rb, rs, rc, m[W-1:0], m[W], m[W+1], $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
